// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner. Each digit slot opens with a short dark
// interval; new data is staged and swapped into the display only at frame boundaries.
module seg_scan_driver #(
  parameter int DIGITS       = 6,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lzb_en,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  load_ack,
  output logic                  frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;
  state_t state;

  logic [CW-1:0]       cnt, cnt_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [4*DIGITS-1:0] disp_dig, disp_dig_nxt, pend_dig;
  logic [DIGITS-1:0]   disp_dp, disp_dp_nxt, pend_dp;
  logic                pend_flag;
  logic                slot_end, frame_end, show_nxt, blank_nxt, zero_run;
  logic [3:0]          nib_nxt;
  logic [DIGITS-1:0]   lead_zero;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Everything the output flops need is computed for the *next* cycle, so the
  // registered outputs line up exactly with the cnt/idx value they describe.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    slot_end     = (cnt == CNT_LAST);
    frame_end    = slot_end && (idx == IDX_LAST);
    cnt_nxt      = slot_end ? '0 : cnt + 1'b1;
    idx_nxt      = idx;
    if (slot_end) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    disp_dig_nxt = disp_dig;
    disp_dp_nxt  = disp_dp;
    if (frame_end && load) begin
      disp_dig_nxt = digits_in;
      disp_dp_nxt  = dp_in;
    end else if (frame_end && pend_flag) begin
      disp_dig_nxt = pend_dig;
      disp_dp_nxt  = pend_dp;
    end

    show_nxt = (state == ST_BLANK) ? (cnt_nxt == CNT_SHOW) : !slot_end;

    nib_nxt = '0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_nxt == IW'(i)) nib_nxt = disp_dig_nxt[4*i +: 4];

    // lead_zero[i]: digit i and every digit above it are zero.
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_dig_nxt[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
    blank_nxt = lzb_en && (idx_nxt != '0) && lead_zero[idx_nxt];
  end

  // A load landing on the boundary commits straight away, so the ack must see it.
  assign load_ack = frame_done && (pend_flag || load);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: display/pending are a handful of flops whose reset contents are visible, so they are reset like any other state.
      state      <= ST_BLANK;
      cnt        <= '0;
      idx        <= '0;
      disp_dig   <= '0;
      disp_dp    <= '0;
      pend_dig   <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      seg_out    <= '0;
      dp_out     <= 1'b0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      disp_dig <= disp_dig_nxt;
      disp_dp  <= disp_dp_nxt;

      if (load && !frame_end) begin
        pend_dig  <= digits_in;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end else if (frame_end) begin
        pend_flag <= 1'b0;
      end

      state <= show_nxt ? ST_SHOW : ST_BLANK;
      if (show_nxt) begin
        dig_sel <= DIGITS'(1) << idx_nxt;
        seg_out <= blank_nxt ? 7'h00 : hex_to_seg(nib_nxt);
        dp_out  <= disp_dp_nxt[idx_nxt];
      end else begin
        dig_sel <= '0;
        seg_out <= '0;
        dp_out  <= 1'b0;
      end

      frame_done <= (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
    end
  end

endmodule
